sc_statemachine_levels: RTL and testbench
=========================================

# sc_statemachine_levels

Parametrised game sequencer FSM for the shift-register play field. It times each level through START/TRANSI/RANDOM/PUFF phases with an internal tick counter, for any number of levels, and lengthens the RANDOM phase per level. It tracks remaining lives, retries the current level on a hit, and reports game-over or win. It sits between the tick prescaler and the field shift-selection multiplexers, and drives their select lines.

## Interface
- NUM_LEVELS, 3: levels per game (≥1).
- LVL_W, 2: width of level index; 2^LVL_W ≥ NUM_LEVELS.
- CNT_W, 8: phase tick-counter width.
- T_START, 8: START duration in ticks.
- T_TRANSI, 16: TRANSI duration in ticks.
- T_RANDOM_BASE, 20: RANDOM duration of level 0 in ticks.
- T_RANDOM_STEP, 10: extra RANDOM ticks per level index.
- T_PUFF, 8: PUFF and HIT duration in ticks.
- LIVES, 3: lives per game (≥1).
- LIFE_W, 2: width of lives counter; 2^LIFE_W > LIVES.

Ports:
- SC_STATEMACHINE_LEVELS_CLOCK_50  in  1  system clock; all logic on rising edge.
- SC_STATEMACHINE_LEVELS_RESET_InLow  in  1  synchronous, active-low reset.
- SC_STATEMACHINE_LEVELS_startButton_InLow  in  1  start button, active low, already debounced.
- SC_STATEMACHINE_LEVELS_tick_In  in  1  one-cycle timebase pulse.
- SC_STATEMACHINE_LEVELS_perdio_In  in  1  collision flag from the field, level-sensitive.
- SC_STATEMACHINE_LEVELS_level_Out  out  LVL_W  current level index.
- SC_STATEMACHINE_LEVELS_phase_Out  out  3  state code: 0 IDLE, 1 START, 2 TRANSI, 3 RANDOM, 4 PUFF, 5 HIT, 6 GAMEOVER, 7 WIN.
- SC_STATEMACHINE_LEVELS_esencial_Out  out  2  field select: START 00; RANDOM 01; GAMEOVER and WIN 11; all other states 10.
- SC_STATEMACHINE_LEVELS_posicion_Out  out  1  player-position enable: 1 in IDLE, ARMED, START and TRANSI; 0 otherwise.
- SC_STATEMACHINE_LEVELS_lives_Out  out  LIFE_W  remaining lives.
- SC_STATEMACHINE_LEVELS_lost_Out  out  1  high in GAMEOVER.
- SC_STATEMACHINE_LEVELS_win_Out  out  1  high in WIN.

## Operation
- States: IDLE, ARMED, START, TRANSI, RANDOM, PUFF, HIT, GAMEOVER, WIN.
  - ARMED reports phase code 0.
- All outputs decode from the state, level and lives registers only (Moore).
- IDLE: when button = 0, go to ARMED.
- ARMED: when button = 1 (release), go to START.
  - Entering START loads level = 0 and lives = LIVES.
- Timed states are START, TRANSI, RANDOM, PUFF and HIT.
  - The tick counter clears on entry to each timed state and increments on each tick.
  - The state ends on the tick that makes the count equal to its duration.
- RANDOM duration = T_RANDOM_BASE + level × T_RANDOM_STEP, computed at CNT_W width. Parameters must not overflow CNT_W.
- Phase sequence:
  - START → TRANSI → RANDOM → PUFF.
  - From PUFF: if level = NUM_LEVELS−1, go to WIN; otherwise increment level and go to TRANSI.
- perdio_In = 1 in RANDOM or PUFF is a hit:
  - If lives = 1: lives → 0, go to GAMEOVER.
  - Otherwise: decrement lives, go to HIT.
- HIT: after T_PUFF ticks, go to TRANSI with level unchanged (the level is retried).
- perdio_In is ignored in IDLE, ARMED, START, TRANSI, HIT, GAMEOVER and WIN.
- GAMEOVER and WIN hold level and lives. Button = 0 → ARMED, which starts a new game on release.
- Illegal state encodings recover to IDLE on the next clock.

## Timing
- Reset (RESET_InLow = 0 at a clock edge) gives:
  - state IDLE, counter 0, level 0, lives = LIVES;
  - phase 0, esencial 10, posicion 1, lost 0, win 0.
- Reset overrides every other input in that cycle.
- Reset mid-game aborts to IDLE with no partial update.
- Transitions take effect on the clock edge after the condition is sampled. Outputs change in the same cycle the state register updates (one-cycle latency from input).
- A tick sampled in the cycle that ends a phase belongs to the ending phase and is not counted in the next one.
- Hit and phase end in the same cycle: the hit wins (HIT or GAMEOVER, no level advance).
- Tick and button in GAMEOVER or WIN in the same cycle: the button is honoured and the tick is ignored.
- A button held low through reset release: IDLE goes to ARMED on the first active cycle, and START follows only after release.

## Test plan
- Default parameters, press then release, no hits:
  - phases run 1→2→3→4 for each level, with level_Out 0,1,2;
  - RANDOM lengths are 20, 30, 40 ticks;
  - after the third PUFF: win_Out = 1, phase 7, lives_Out = 3.
- Hit in level 1 RANDOM at tick 5:
  - lives 3→2, phase 5 for 8 ticks;
  - then phase 2 with level_Out still 1, and the full 30-tick RANDOM replays.
- Three hits (LIVES = 3): on the third, lives_Out = 0, phase 6, lost_Out = 1, esencial 11. A further perdio causes no change.
- perdio_In asserted in the same cycle as the final RANDOM tick: HIT is entered and PUFF is not.
- Reset asserted in level 2 PUFF: the next cycle shows phase 0, level 0, lives 3, esencial 10, posicion 1. Holding the button low keeps ARMED until release.
- NUM_LEVELS = 1, LIVES = 1: a single level; the first hit goes to GAMEOVER; a clean PUFF goes to WIN; the tick counter starts from 0 in each phase.

Source files
------------

// File: rtl/sc_statemachine_levels.sv
// Game sequencer for the shift-register play field: times START/TRANSI/RANDOM/PUFF
// per level, tracks lives, retries a level on a hit and reports game-over or win.
module sc_statemachine_levels #(
    parameter int NUM_LEVELS    = 3,
    parameter int LVL_W         = 2,
    parameter int CNT_W         = 8,
    parameter int T_START       = 8,
    parameter int T_TRANSI      = 16,
    parameter int T_RANDOM_BASE = 20,
    parameter int T_RANDOM_STEP = 10,
    parameter int T_PUFF        = 8,
    parameter int LIVES         = 3,
    parameter int LIFE_W        = 2
) (
    input  logic              SC_STATEMACHINE_LEVELS_CLOCK_50,
    input  logic              SC_STATEMACHINE_LEVELS_RESET_InLow,
    input  logic              SC_STATEMACHINE_LEVELS_startButton_InLow,
    input  logic              SC_STATEMACHINE_LEVELS_tick_In,
    input  logic              SC_STATEMACHINE_LEVELS_perdio_In,
    output logic [LVL_W-1:0]  SC_STATEMACHINE_LEVELS_level_Out,
    output logic [2:0]        SC_STATEMACHINE_LEVELS_phase_Out,
    output logic [1:0]        SC_STATEMACHINE_LEVELS_esencial_Out,
    output logic              SC_STATEMACHINE_LEVELS_posicion_Out,
    output logic [LIFE_W-1:0] SC_STATEMACHINE_LEVELS_lives_Out,
    output logic              SC_STATEMACHINE_LEVELS_lost_Out,
    output logic              SC_STATEMACHINE_LEVELS_win_Out
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ARMED    = 4'd1,
        S_START    = 4'd2,
        S_TRANSI   = 4'd3,
        S_RANDOM   = 4'd4,
        S_PUFF     = 4'd5,
        S_HIT      = 4'd6,
        S_GAMEOVER = 4'd7,
        S_WIN      = 4'd8
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [CNT_W-1:0]  w_dur;
    logic [LVL_W-1:0]  r_level;
    logic [LVL_W-1:0]  w_level_next;
    logic [LIFE_W-1:0] r_lives;
    logic [LIFE_W-1:0] w_lives_next;
    logic              w_timed;
    logic              w_done;
    logic              w_btn_pressed;

    assign w_btn_pressed = ~SC_STATEMACHINE_LEVELS_startButton_InLow;
    assign w_cnt_inc     = r_cnt + CNT_W'(1);
    assign w_done        = w_timed && SC_STATEMACHINE_LEVELS_tick_In && (w_cnt_inc == w_dur);

    always_comb begin
        w_timed = 1'b1;
        w_dur   = '0;
        case (r_state)
            S_START:  w_dur = CNT_W'(T_START);
            S_TRANSI: w_dur = CNT_W'(T_TRANSI);
            S_RANDOM: w_dur = CNT_W'(T_RANDOM_BASE) + CNT_W'(r_level) * CNT_W'(T_RANDOM_STEP);
            S_PUFF:   w_dur = CNT_W'(T_PUFF);
            S_HIT:    w_dur = CNT_W'(T_PUFF);
            default:  w_timed = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_level_next = r_level;
        w_lives_next = r_lives;
        case (r_state)
            S_IDLE:   if (w_btn_pressed) w_state_next = S_ARMED;
            S_ARMED: begin
                if (!w_btn_pressed) begin
                    w_state_next = S_START;
                    w_level_next = '0;
                    w_lives_next = LIFE_W'(LIVES);
                end
            end
            S_START:  if (w_done) w_state_next = S_TRANSI;
            S_TRANSI: if (w_done) w_state_next = S_RANDOM;
            S_RANDOM, S_PUFF: begin
                // A hit outranks a phase ending in the same cycle.
                if (SC_STATEMACHINE_LEVELS_perdio_In) begin
                    w_lives_next = r_lives - LIFE_W'(1);
                    w_state_next = (r_lives == LIFE_W'(1)) ? S_GAMEOVER : S_HIT;
                end else if (w_done) begin
                    if (r_state == S_RANDOM) begin
                        w_state_next = S_PUFF;
                    end else if (r_level == LVL_W'(NUM_LEVELS - 1)) begin
                        w_state_next = S_WIN;
                    end else begin
                        w_level_next = r_level + LVL_W'(1);
                        w_state_next = S_TRANSI;
                    end
                end
            end
            S_HIT:    if (w_done) w_state_next = S_TRANSI;
            S_GAMEOVER, S_WIN: if (w_btn_pressed) w_state_next = S_ARMED;
            default:  w_state_next = S_IDLE;
        endcase

        w_cnt_next = r_cnt;
        if (w_state_next != r_state || !w_timed) begin
            w_cnt_next = '0;
        end else if (SC_STATEMACHINE_LEVELS_tick_In) begin
            w_cnt_next = w_cnt_inc;
        end
    end

    always_ff @(posedge SC_STATEMACHINE_LEVELS_CLOCK_50) begin
        if (!SC_STATEMACHINE_LEVELS_RESET_InLow) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_level <= '0;
            r_lives <= LIFE_W'(LIVES);
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_level <= w_level_next;
            r_lives <= w_lives_next;
        end
    end

    always_comb begin
        SC_STATEMACHINE_LEVELS_phase_Out    = 3'd0;
        SC_STATEMACHINE_LEVELS_esencial_Out = 2'b10;
        SC_STATEMACHINE_LEVELS_posicion_Out = 1'b0;
        case (r_state)
            S_IDLE, S_ARMED: SC_STATEMACHINE_LEVELS_posicion_Out = 1'b1;
            S_START: begin
                SC_STATEMACHINE_LEVELS_phase_Out    = 3'd1;
                SC_STATEMACHINE_LEVELS_esencial_Out = 2'b00;
                SC_STATEMACHINE_LEVELS_posicion_Out = 1'b1;
            end
            S_TRANSI: begin
                SC_STATEMACHINE_LEVELS_phase_Out    = 3'd2;
                SC_STATEMACHINE_LEVELS_posicion_Out = 1'b1;
            end
            S_RANDOM: begin
                SC_STATEMACHINE_LEVELS_phase_Out    = 3'd3;
                SC_STATEMACHINE_LEVELS_esencial_Out = 2'b01;
            end
            S_PUFF:     SC_STATEMACHINE_LEVELS_phase_Out = 3'd4;
            S_HIT:      SC_STATEMACHINE_LEVELS_phase_Out = 3'd5;
            S_GAMEOVER: begin
                SC_STATEMACHINE_LEVELS_phase_Out    = 3'd6;
                SC_STATEMACHINE_LEVELS_esencial_Out = 2'b11;
            end
            S_WIN: begin
                SC_STATEMACHINE_LEVELS_phase_Out    = 3'd7;
                SC_STATEMACHINE_LEVELS_esencial_Out = 2'b11;
            end
            default: SC_STATEMACHINE_LEVELS_posicion_Out = 1'b1;
        endcase
    end

    assign SC_STATEMACHINE_LEVELS_level_Out = r_level;
    assign SC_STATEMACHINE_LEVELS_lives_Out = r_lives;
    assign SC_STATEMACHINE_LEVELS_lost_Out  = (r_state == S_GAMEOVER);
    assign SC_STATEMACHINE_LEVELS_win_Out   = (r_state == S_WIN);

endmodule

// File: tb/tb_sc_statemachine_levels.sv
// Scoreboard bench: expected output snapshots are queued as stimulus is driven and
// compared, with the tick count of the phase just left, whenever the outputs change.
module tb_sc_statemachine_levels;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic tick = 1'b0;
    logic btn = 1'b1;
    logic perdio = 1'b0;
    logic btn1 = 1'b1;
    logic perdio1 = 1'b0;

    logic [1:0] level;
    logic [2:0] phase;
    logic [1:0] esen;
    logic       pos;
    logic [1:0] lives;
    logic       lost;
    logic       win;

    logic [0:0] level1;
    logic [2:0] phase1;
    logic [1:0] esen1;
    logic       pos1;
    logic [0:0] lives1;
    logic       lost1;
    logic       win1;

    sc_statemachine_levels dut (
        .SC_STATEMACHINE_LEVELS_CLOCK_50        (clk),
        .SC_STATEMACHINE_LEVELS_RESET_InLow     (rst_n),
        .SC_STATEMACHINE_LEVELS_startButton_InLow(btn),
        .SC_STATEMACHINE_LEVELS_tick_In         (tick),
        .SC_STATEMACHINE_LEVELS_perdio_In       (perdio),
        .SC_STATEMACHINE_LEVELS_level_Out       (level),
        .SC_STATEMACHINE_LEVELS_phase_Out       (phase),
        .SC_STATEMACHINE_LEVELS_esencial_Out    (esen),
        .SC_STATEMACHINE_LEVELS_posicion_Out    (pos),
        .SC_STATEMACHINE_LEVELS_lives_Out       (lives),
        .SC_STATEMACHINE_LEVELS_lost_Out        (lost),
        .SC_STATEMACHINE_LEVELS_win_Out         (win)
    );

    sc_statemachine_levels #(
        .NUM_LEVELS(1), .LVL_W(1), .LIVES(1), .LIFE_W(1)
    ) dut1 (
        .SC_STATEMACHINE_LEVELS_CLOCK_50        (clk),
        .SC_STATEMACHINE_LEVELS_RESET_InLow     (rst_n),
        .SC_STATEMACHINE_LEVELS_startButton_InLow(btn1),
        .SC_STATEMACHINE_LEVELS_tick_In         (tick),
        .SC_STATEMACHINE_LEVELS_perdio_In       (perdio1),
        .SC_STATEMACHINE_LEVELS_level_Out       (level1),
        .SC_STATEMACHINE_LEVELS_phase_Out       (phase1),
        .SC_STATEMACHINE_LEVELS_esencial_Out    (esen1),
        .SC_STATEMACHINE_LEVELS_posicion_Out    (pos1),
        .SC_STATEMACHINE_LEVELS_lives_Out       (lives1),
        .SC_STATEMACHINE_LEVELS_lost_Out        (lost1),
        .SC_STATEMACHINE_LEVELS_win_Out         (win1)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("[TB] ok %s = 0x%0h", tag, obs);
        end
    endtask

    // Snapshot layout: {phase, level, lives, esencial, posicion, lost, win}
    typedef struct {
        logic [11:0] outs;
        int          ticks;
        string       tag;
    } exp_t;

    exp_t sb_q[$];

    task automatic push(input string tag, input logic [2:0] p, input logic [1:0] l,
                        input logic [1:0] v, input int t);
        exp_t e;
        logic [1:0] es;
        es = (p == 3'd1) ? 2'b00 : (p == 3'd3) ? 2'b01 : (p >= 3'd6) ? 2'b11 : 2'b10;
        e.outs  = {p, l, v, es, (p <= 3'd2), (p == 3'd6), (p == 3'd7)};
        e.ticks = t;
        e.tag   = tag;
        sb_q.push_back(e);
    endtask

    logic        mon_en = 1'b0;
    logic [11:0] prev_outs;
    int          tcnt = 0;

    always @(negedge clk) begin
        logic [11:0] cur;
        exp_t e;
        cur = {phase, level, lives, esen, pos, lost, win};
        if (!mon_en) begin
            prev_outs = cur;
            tcnt = 0;
        end else begin
            if (cur !== prev_outs) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_change", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check({e.tag, "_outs"}, 32'(cur), 32'(e.outs));
                    if (e.ticks >= 0) check({e.tag, "_prev_ticks"}, 32'(tcnt), 32'(e.ticks));
                end
                prev_outs = cur;
                tcnt = 0;
            end
            if (tick) tcnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
            cyc(1);
        end
    endtask

    task automatic run_level(input logic [1:0] l, input logic [1:0] v);
        push("transi", 3'd2, l, v, 8);
        ticks(8);
        push("random", 3'd3, l, v, 16);
        ticks(16);
        push("puff", 3'd4, l, v, 20 + 10 * int'(l));
        ticks(20 + 10 * int'(l));
    endtask

    task automatic drain(input string tag);
        cyc(2);
        check(tag, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        cyc(3);
        rst_n = 1'b1;
        cyc(1);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_lives", 32'(lives), 32'd3);
        check("rst_esen", 32'(esen), 32'b10);
        check("rst_pos", 32'(pos), 32'd1);
        check("rst_lost_win", 32'({lost, win}), 32'd0);
        mon_en = 1'b1;
        cyc(1);

        // Game 1: clean run to WIN
        push("start", 3'd1, 2'd0, 2'd3, 0);
        btn = 1'b0; cyc(2); btn = 1'b1;
        cyc(1);
        push("transi", 3'd2, 2'd0, 2'd3, 8);
        ticks(8);
        push("random", 3'd3, 2'd0, 2'd3, 16);
        ticks(16);
        push("puff", 3'd4, 2'd0, 2'd3, 20);
        ticks(20);
        run_level(2'd1, 2'd3);
        run_level(2'd2, 2'd3);
        push("win", 3'd7, 2'd2, 2'd3, 8);
        ticks(8);
        ticks(3);
        drain("g1_drain");

        // Button and tick together in WIN: button wins
        push("win_to_armed", 3'd0, 2'd2, 2'd3, -1);
        btn = 1'b0; tick = 1'b1; cyc(1); tick = 1'b0; cyc(2);
        push("restart", 3'd1, 2'd0, 2'd3, 0);
        btn = 1'b1; cyc(2);

        // Game 2: hits, retry, simultaneous hit/final tick, game over
        push("transi", 3'd2, 2'd0, 2'd3, 8);
        ticks(8);
        push("random", 3'd3, 2'd0, 2'd3, 16);
        ticks(16);
        push("puff", 3'd4, 2'd0, 2'd3, 20);
        ticks(20);
        push("transi", 3'd2, 2'd1, 2'd3, 8);
        ticks(8);
        push("random", 3'd3, 2'd1, 2'd3, 16);
        ticks(16);
        ticks(5);
        push("hit1", 3'd5, 2'd1, 2'd2, 5);
        perdio = 1'b1; cyc(1); perdio = 1'b0; cyc(1);
        push("retry_transi", 3'd2, 2'd1, 2'd2, 8);
        ticks(8);
        push("retry_random", 3'd3, 2'd1, 2'd2, 16);
        ticks(16);
        push("retry_puff", 3'd4, 2'd1, 2'd2, 30);
        ticks(30);
        push("transi", 3'd2, 2'd2, 2'd2, 8);
        ticks(8);
        push("random", 3'd3, 2'd2, 2'd2, 16);
        ticks(16);
        ticks(39);
        push("hit_on_last_tick", 3'd5, 2'd2, 2'd1, 40);
        tick = 1'b1; perdio = 1'b1; cyc(1); tick = 1'b0; perdio = 1'b0; cyc(1);
        push("transi", 3'd2, 2'd2, 2'd1, 8);
        ticks(8);
        push("random", 3'd3, 2'd2, 2'd1, 16);
        ticks(16);
        ticks(3);
        push("gameover", 3'd6, 2'd2, 2'd0, 3);
        perdio = 1'b1; cyc(1); perdio = 1'b0; cyc(1);
        perdio = 1'b1; cyc(2); perdio = 1'b0;
        ticks(4);
        drain("g2_drain");

        // Game 3: reset during level 2 PUFF with button held low
        push("go_to_armed", 3'd0, 2'd2, 2'd0, -1);
        btn = 1'b0; cyc(2);
        push("restart", 3'd1, 2'd0, 2'd3, 0);
        btn = 1'b1; cyc(2);
        push("transi", 3'd2, 2'd0, 2'd3, 8);
        ticks(8);
        push("random", 3'd3, 2'd0, 2'd3, 16);
        ticks(16);
        push("puff", 3'd4, 2'd0, 2'd3, 20);
        ticks(20);
        run_level(2'd1, 2'd3);
        run_level(2'd2, 2'd3);
        ticks(3);
        push("reset_abort", 3'd0, 2'd0, 2'd3, 3);
        btn = 1'b0; rst_n = 1'b0; cyc(1);
        rst_n = 1'b1; cyc(6);
        check("armed_held_phase", 32'(phase), 32'd0);
        push("start_after_release", 3'd1, 2'd0, 2'd3, 0);
        btn = 1'b1; cyc(2);
        drain("g3_drain");

        // Single level, single life instance
        mon_en = 1'b0;
        rst_n = 1'b0; btn = 1'b1; cyc(2); rst_n = 1'b1; cyc(1);
        btn1 = 1'b0; cyc(2); btn1 = 1'b1; cyc(1);
        check("n1_start", 32'(phase1), 32'd1);
        ticks(7);
        check("n1_start_hold", 32'(phase1), 32'd1);
        ticks(1);
        check("n1_transi", 32'(phase1), 32'd2);
        ticks(16);
        check("n1_random", 32'(phase1), 32'd3);
        ticks(20);
        check("n1_puff", 32'(phase1), 32'd4);
        ticks(8);
        check("n1_win", 32'({phase1, level1, lives1, win1}), 32'({3'd7, 1'b0, 1'b1, 1'b1}));
        btn1 = 1'b0; cyc(2); btn1 = 1'b1; cyc(2);
        check("n1_restart", 32'(phase1), 32'd1);
        ticks(24);
        check("n1_random2", 32'(phase1), 32'd3);
        perdio1 = 1'b1; cyc(1); perdio1 = 1'b0; cyc(1);
        check("n1_gameover", 32'({phase1, lives1, lost1, esen1}), 32'({3'd6, 1'b0, 1'b1, 2'b11}));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
